// File: rtl/gcn_agg_scheduler.sv
// -----------------------------------------------------------------------------
// gcn_agg_scheduler
//
// Purpose:
//   Schedules the neighbour-aggregation step of a graph convolution layer for
//   N_CH feature columns at once. A job streams one feature element per row
//   (x[r] for every channel). For each row the block scans every column k of
//   the adjacency row and adds x[r] into acc[ch][k] wherever adj[r][k] = 1.
//   When all rows are done, the accumulators are drained channel-major on a
//   valid/ready output port. Each beat carries the channel, that channel's
//   column tag, the node number and the aggregated value.
//
// Configuration:
//   GCN_AGG_SAT_EN - when defined, accumulators saturate at 2^DATA_W-1.
//                    When undefined, accumulators wrap modulo 2^DATA_W.
//
// Ports:
//   clk        - single rising-edge clock
//   rst        - synchronous, active-low reset (adjacency is left untouched)
//   adj_we     - adjacency write strobe, honoured only while idle
//   adj_row    - adjacency write row
//   adj_col    - adjacency write column
//   adj_bit    - adjacency write value
//   start      - begin a job (honoured only while idle and not on a done cycle)
//   start_idx  - per-channel column tags, channel 0 in the LSBs
//   in_valid   - feature element for the current row is valid
//   in_ready   - block is waiting for the next row's features
//   in_data    - per-channel feature element, channel 0 in the LSBs
//   out_valid  - drain beat valid
//   out_ready  - downstream accepts the drain beat
//   out_ch     - channel of the current beat
//   out_idx    - latched column tag of out_ch
//   out_node   - node number of the current beat
//   out_data   - aggregated value acc[out_ch][out_node]
//   busy       - a job is in progress
//   done       - one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module gcn_agg_scheduler #(
    parameter int DATA_W  = 16,
    parameter int N_NODES = 100,
    parameter int N_CH    = 2,
    parameter int IDX_W   = 3,
    localparam int CNT_W  = (N_NODES > 1) ? $clog2(N_NODES) : 1,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    adj_we,
    input  logic [CNT_W-1:0]        adj_row,
    input  logic [CNT_W-1:0]        adj_col,
    input  logic                    adj_bit,

    input  logic                    start,
    input  logic [N_CH*IDX_W-1:0]   start_idx,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*DATA_W-1:0]  in_data,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [IDX_W-1:0]        out_idx,
    output logic [CNT_W-1:0]        out_node,
    output logic [DATA_W-1:0]       out_data,

    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LAST_NODE = CNT_W'(N_NODES - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   r_q, r_d;          // adjacency row being processed
    logic [CNT_W-1:0]   k_q, k_d;          // adjacency column being scanned
    logic [CH_W-1:0]    ch_q, ch_d;        // drain channel (drives out_ch)
    logic [CNT_W-1:0]   node_q, node_d;    // drain node (drives out_node)

    logic [IDX_W-1:0]   tag_q [N_CH];
    logic [IDX_W-1:0]   tag_d [N_CH];
    logic [DATA_W-1:0]  x_q   [N_CH];
    logic [DATA_W-1:0]  x_d   [N_CH];
    logic [DATA_W-1:0]  acc_q [N_CH][N_NODES];
    logic [DATA_W-1:0]  acc_d [N_CH][N_NODES];

    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               done_q, done_d;

    logic [N_NODES-1:0] adj_q [N_NODES];
    logic [N_NODES-1:0] adj_d [N_NODES];

    logic [CH_W-1:0]    ch_inc;
    logic [CNT_W-1:0]   node_inc;

    // -------------------------------------------------------------------------
    // Accumulate one feature element into one accumulator
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
`ifdef GCN_AGG_SAT_EN
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        // Inputs are unsigned, so once at the ceiling the sum can never fall
        // back below it: saturation persists for the rest of the job.
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
        return a + b;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Adjacency memory
    // -------------------------------------------------------------------------
    always_comb begin
        adj_d = adj_q;
        // Writes mid-job would change the graph under a running scan.
        if (adj_we && (state_q == IDLE)) begin
            adj_d[adj_row][adj_col] = adj_bit;
        end
    end

    // NOTE: the adjacency is configuration storage, not control state; it has
    // no reset so that a reset between jobs keeps the loaded graph.
    always_ff @(posedge clk) begin
        adj_q <= adj_d;
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    // NOTE: every variable gets its hold value before the case statement, so
    // any path that does not assign it keeps the flop value instead of
    // inferring a latch.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        k_d         = k_q;
        ch_d        = ch_q;
        node_d      = node_q;
        tag_d       = tag_q;
        x_d         = x_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        ch_inc      = ch_q + 1'b1;
        node_inc    = node_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                // done_q is high only on the first idle cycle after a job;
                // a start there is dropped.
                if (start && !done_q) begin
                    for (int c = 0; c < N_CH; c++) begin
                        tag_d[c] = start_idx[c*IDX_W +: IDX_W];
                        for (int n = 0; n < N_NODES; n++) begin
                            acc_d[c][n] = '0;
                        end
                    end
                    r_d     = '0;
                    k_d     = '0;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                if (in_valid) begin
                    for (int c = 0; c < N_CH; c++) begin
                        x_d[c] = in_data[c*DATA_W +: DATA_W];
                    end
                    k_d     = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                // NOTE: blocking assignments here build the next-state value
                // combinationally; only the always_ff blocks use <= to update
                // the flops, so the read of acc_d below sees this cycle's add.
                for (int c = 0; c < N_CH; c++) begin
                    if (adj_q[r_q][k_q]) begin
                        acc_d[c][k_q] = acc_add(acc_q[c][k_q], x_q[c]);
                    end
                end

                if (k_q == LAST_NODE) begin
                    k_d = '0;
                    if (r_q == LAST_NODE) begin
                        // Preload the first beat so out_* come straight from flops.
                        state_d     = DRAIN;
                        ch_d        = '0;
                        node_d      = '0;
                        out_valid_d = 1'b1;
                        out_idx_d   = tag_q[0];
                        out_data_d  = acc_d[0][0];
                    end else begin
                        r_d     = r_q + 1'b1;
                        state_d = LOAD;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            DRAIN: begin
                // out_valid_q is always 1 here, so out_ready alone is the
                // handshake. Without it every out_* register holds.
                if (out_ready) begin
                    if ((ch_q == LAST_CH) && (node_q == LAST_NODE)) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        out_valid_d = 1'b0;
                        ch_d        = '0;
                        node_d      = '0;
                        out_idx_d   = '0;
                        out_data_d  = '0;
                    end else if (node_q == LAST_NODE) begin
                        ch_d       = ch_inc;
                        node_d     = '0;
                        out_idx_d  = tag_q[ch_inc];
                        out_data_d = acc_q[ch_inc][0];
                    end else begin
                        node_d     = node_inc;
                        out_data_d = acc_q[ch_q][node_inc];
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            k_q         <= '0;
            ch_q        <= '0;
            node_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                tag_q[c] <= '0;
                x_q[c]   <= '0;
                for (int n = 0; n < N_NODES; n++) begin
                    acc_q[c][n] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            k_q         <= k_d;
            ch_q        <= ch_d;
            node_q      <= node_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            tag_q       <= tag_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_ch    = ch_q;
    assign out_idx   = out_idx_q;
    assign out_node  = node_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule
